// File: rtl/image_mem_scheduler.sv
// image_mem_scheduler
//   Owns the single port of the 28x28 image memory and shares it between
//   the cursor writer, the VGA reader, a full-image clear sweep and a burst
//   streamer that hands every pixel, in order, to the inference datapath.
//   Writes are frozen while a stream runs, so inference sees one snapshot.
//
// Ports
//   CLOCK_50, reset          clock, synchronous active-high reset
//   clear_start / clear_busy start / status of the zeroing sweep
//   wr_req/addr/data, wr_ack draw write, held until the 1-cycle ack
//   vga_req/addr, vga_ack    display read, held until the 1-cycle ack
//   vga_rvalid, vga_rdata    read data, one cycle after vga_ack
//   nn_start, nn_busy        stream start pulse / stream in progress
//   nn_valid/ready/data/index/last  pixel stream with backpressure
//   nn_done                  pulse the cycle after the final transfer
//   mem_addr/wdata/we        to image_memory (combinational from grant)
//   mem_rdata                from image_memory, valid cycle after address
module image_mem_scheduler #(
  parameter int GRID_SIZE  = 28,
  parameter int NUM_PIXELS = GRID_SIZE * GRID_SIZE,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  clear_start,
  output logic                  clear_busy,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_ack,
  output logic                  vga_rvalid,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  input  logic                  nn_start,
  output logic                  nn_busy,
  output logic                  nn_valid,
  input  logic                  nn_ready,
  output logic [DATA_WIDTH-1:0] nn_data,
  output logic [9:0]            nn_index,
  output logic                  nn_last,
  output logic                  nn_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [9:0]            LAST_IDX = 10'(NUM_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] NPIX_A   = ADDR_WIDTH'(NUM_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM} state_t;

  state_t                state;
  logic [9:0]            clr_cnt;
  logic                  clear_pending;
  logic                  rr_last_nn;   // 1: NN won the last NN/VGA grant
  logic [9:0]            iss_idx;      // next pixel to read
  logic                  iss_done;     // all pixels issued
  logic                  inflight;     // NN read issued last cycle
  logic [9:0]            infl_idx;
  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [9:0]            fifo_idx  [2];
  logic                  vga_oor;

  logic gnt_wr, gnt_vga, gnt_nn, nn_elig, pop, wr_oor;

  assign wr_oor  = wr_addr >= NPIX_A;
  // Reads already in flight count against the FIFO so a landing word
  // always has a slot, whatever the consumer does.
  assign nn_elig = (state == S_STREAM) && !iss_done &&
                   (({1'b0, fifo_cnt} + {2'b0, inflight}) < 3'd2);

  assign nn_valid = fifo_cnt != 2'd0;
  assign nn_data  = nn_valid ? fifo_data[0] : '0;
  assign nn_index = nn_valid ? fifo_idx[0]  : '0;
  assign nn_last  = nn_valid && (fifo_idx[0] == LAST_IDX);
  assign pop      = nn_valid && nn_ready;

  assign vga_rdata = (vga_rvalid && !vga_oor) ? mem_rdata : '0;
  assign wr_ack    = gnt_wr;
  assign vga_ack   = gnt_vga;

  // Grant and memory drive. Nothing is granted while reset is held, so a
  // reset landing mid-sweep stops the write of that very cycle.
  always_comb begin
    gnt_wr    = 1'b0;
    gnt_vga   = 1'b0;
    gnt_nn    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (wr_req)       gnt_wr  = 1'b1;
          else if (vga_req) gnt_vga = 1'b1;
        end
        S_CLEAR: begin
          mem_we   = 1'b1;
          mem_addr = ADDR_WIDTH'(clr_cnt);
        end
        S_STREAM: begin
          if (nn_elig && vga_req) begin
            if (rr_last_nn) gnt_vga = 1'b1;
            else            gnt_nn  = 1'b1;
          end else if (nn_elig) begin
            gnt_nn = 1'b1;
          end else if (vga_req) begin
            gnt_vga = 1'b1;
          end
        end
        default: ;
      endcase
      if (gnt_wr) begin
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_we    = !wr_oor;   // out-of-range writes are acked but dropped
      end else if (gnt_vga) begin
        mem_addr = vga_addr;
      end else if (gnt_nn) begin
        mem_addr = ADDR_WIDTH'(iss_idx);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= S_IDLE;
      clr_cnt       <= '0;
      clear_pending <= 1'b0;
      clear_busy    <= 1'b0;
      rr_last_nn    <= 1'b0;
      nn_busy       <= 1'b0;
      nn_done       <= 1'b0;
      iss_idx       <= '0;
      iss_done      <= 1'b0;
      inflight      <= 1'b0;
      infl_idx      <= '0;
      fifo_cnt      <= '0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_idx[0]   <= '0;
      fifo_idx[1]   <= '0;
      vga_rvalid    <= 1'b0;
      vga_oor       <= 1'b0;
    end else begin
      nn_done    <= 1'b0;
      vga_rvalid <= gnt_vga;
      vga_oor    <= vga_addr >= NPIX_A;
      inflight   <= gnt_nn;
      infl_idx   <= iss_idx;
      if (gnt_nn)       rr_last_nn <= 1'b1;
      else if (gnt_vga) rr_last_nn <= 1'b0;

      case (state)
        S_IDLE: begin
          // A pending clear from the last stream behaves like a fresh
          // clear_start and, likewise, beats a same-cycle nn_start.
          if (clear_start || clear_pending) begin
            state         <= S_CLEAR;
            clear_busy    <= 1'b1;
            clear_pending <= 1'b0;
            clr_cnt       <= '0;
          end else if (nn_start) begin
            state    <= S_STREAM;
            nn_busy  <= 1'b1;
            iss_idx  <= '0;
            iss_done <= 1'b0;
            fifo_cnt <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state      <= S_IDLE;
            clear_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 10'd1;
          end
        end
        S_STREAM: begin
          if (clear_start) clear_pending <= 1'b1;
          if (gnt_nn) begin
            if (iss_idx == LAST_IDX) iss_done <= 1'b1;
            else                     iss_idx  <= iss_idx + 10'd1;
          end
          // Two-entry FIFO, head in slot 0.
          case ({inflight, pop})
            2'b10: begin
              fifo_data[fifo_cnt[0]] <= mem_rdata;
              fifo_idx[fifo_cnt[0]]  <= infl_idx;
              fifo_cnt               <= fifo_cnt + 2'd1;
            end
            2'b01: begin
              fifo_data[0] <= fifo_data[1];
              fifo_idx[0]  <= fifo_idx[1];
              fifo_cnt     <= fifo_cnt - 2'd1;
            end
            2'b11: begin
              if (fifo_cnt == 2'd1) begin
                fifo_data[0] <= mem_rdata;
                fifo_idx[0]  <= infl_idx;
              end else begin
                fifo_data[0] <= fifo_data[1];
                fifo_idx[0]  <= fifo_idx[1];
                fifo_data[1] <= mem_rdata;
                fifo_idx[1]  <= infl_idx;
              end
            end
            default: ;
          endcase
          if (pop && (fifo_idx[0] == LAST_IDX)) begin
            state   <= S_IDLE;
            nn_busy <= 1'b0;
            nn_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/image_mem_scheduler.md
Name: image_mem_scheduler

Overview:
- Arbitrates the single-port 28x28 image memory (784 words, 32-bit signed, 1-cycle read latency) between four users:
  - the cursor drawing writer;
  - the VGA refresh reader;
  - a full-image clear engine;
  - a burst streamer that feeds all 784 pixels, in order, to the inference datapath with valid/ready backpressure.
- Sits between the drawing-grid front end and image_memory; the NN input layer consumes the stream port.
- Freezes writes during a stream so inference always sees a consistent image snapshot.

Parameters:
GRID_SIZE, 28, pixels per row/column
NUM_PIXELS, 784, total words swept or streamed (GRID_SIZE*GRID_SIZE)
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 32, memory word width (signed)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high
clear_start  in  1  pulse: zero entire image
clear_busy  out  1  clear sweep in progress
wr_req  in  1  draw write request; held until wr_ack
wr_addr  in  ADDR_WIDTH  draw write address
wr_data  in  DATA_WIDTH  draw write data
wr_ack  out  1  1-cycle pulse: write accepted this cycle
vga_req  in  1  display read request; held until vga_ack
vga_addr  in  ADDR_WIDTH  display read address
vga_ack  out  1  1-cycle pulse: read issued this cycle
vga_rvalid  out  1  vga_rdata valid (cycle after vga_ack)
vga_rdata  out  DATA_WIDTH  display read data
nn_start  in  1  pulse: begin streaming image
nn_busy  out  1  stream in progress
nn_valid  out  1  nn_data/nn_index valid
nn_ready  in  1  consumer accepts when nn_valid&nn_ready
nn_data  out  DATA_WIDTH  pixel value
nn_index  out  10  pixel index 0..NUM_PIXELS-1
nn_last  out  1  high with index NUM_PIXELS-1
nn_done  out  1  1-cycle pulse after final transfer
mem_addr  out  ADDR_WIDTH  to image_memory
mem_wdata  out  DATA_WIDTH  to image_memory
mem_we  out  1  to image_memory
mem_rdata  in  DATA_WIDTH  from image_memory, valid cycle after address

Behaviour:
- Reset:
  - All outputs 0, FSM to IDLE, stream FIFO emptied, clear_pending and RR pointer cleared.
  - Reset mid-clear or mid-stream abandons the operation; no nn_done is emitted.
- Memory interface:
  - At most one memory operation per cycle.
  - mem_addr/mem_we/mem_wdata are combinational from the grant; the ack pulses in the same cycle.
  - With no grant: mem_we=0, mem_addr=0.
- FSM states: IDLE, CLEAR, STREAM.
- IDLE:
  - clear_start → CLEAR next cycle. If clear_start and nn_start arrive in the same cycle, clear wins and nn_start is dropped.
  - nn_start → STREAM, nn_busy=1 next cycle.
  - Grants: wr_req has priority over vga_req.
- CLEAR:
  - clear_busy=1; writes 0 to addresses 0..NUM_PIXELS-1, one per cycle.
  - Exclusive: no wr_ack or vga_ack is granted.
  - Occupies exactly NUM_PIXELS cycles; clear_busy falls the cycle after the address 783 write.
  - clear_start while busy is ignored.
- STREAM:
  - wr_ack is withheld for the whole stream (writer stalls).
  - An NN read is eligible when there are unissued pixels and (FIFO occupancy + in-flight reads) < 2.
  - Eligible NN reads and vga_req share the port round-robin: on conflict, grant whichever was not granted last; a lone requester always wins.
  - Read data lands in a 2-entry FIFO driving nn_valid/nn_data/nn_index.
  - Outputs hold stable while nn_valid & !nn_ready.
  - nn_last accompanies index 783.
  - nn_done pulses the cycle after the last transfer; nn_busy falls in that same cycle; then return to IDLE, or to CLEAR if clear_pending.
  - clear_start during STREAM sets clear_pending (single-entry; repeats coalesce).
  - nn_start during STREAM is ignored.
- Out-of-range addresses (≥ NUM_PIXELS):
  - A write is acked with mem_we=0 (dropped).
  - A VGA read is acked and vga_rdata returns 0.
- vga_rvalid/vga_rdata follow vga_ack by exactly 1 cycle.
- Widths:
  - nn_index is a 10-bit counter and never wraps (stops at 783).
  - Clear and stream counters are 10-bit, compared against NUM_PIXELS-1.

Test Plan:
- Clear: reset, clear_start at cycle 5 → mem_we=1, mem_wdata=0, for addresses 0..783 in cycles 6..789; clear_busy falls at cycle 790; a wr_req held throughout gets wr_ack at cycle 790.
- Write vs VGA in IDLE: wr_req(addr 29, data 1) and vga_req(addr 29) in the same cycle → wr_ack first; vga_ack next cycle; vga_rdata=1 one cycle later.
- Stream with nn_ready=1, memory preloaded with value = index → 784 transfers, data 0..783 in order; nn_last on 783; nn_done one cycle later; no wr_ack during nn_busy.
- Backpressure: nn_ready toggling 1/0 each cycle, plus random 3-cycle stalls → no loss or duplication; FIFO never holds more than 2 entries; data stable during stalls.
- Round-robin: continuous vga_req during STREAM with nn_ready=1 → NN and VGA grants alternate; each completes with no starvation.
- clear_start at stream index 100 → stream completes with unmodified data; CLEAR begins the cycle after nn_done. Reset at clear address 400 → clear_busy=0 next cycle; addresses 400..783 untouched.
